gpu_node_router: RTL and testbench

GPU_NODE_ROUTER -- requirements
Module: gpu_node_router

---
 rtl/gpu_node_router.sv | 198 +++++++++++++++++++
 tb/tb_gpu_node_router.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gpu_node_router.sv
// gpu_node_router: one-GPU leaf router with a local NI port and NUM_SPINES spine ports.
// Every input has a FIFO_DEPTH-deep FIFO, and every output has one register stage.
// The local input routes to gpu_out (loopback) or to a spine. Spine inputs route only
// to gpu_out; anything else arriving on a spine is discarded.
// Optional build macro GPU_NODE_ROUTER_STATS_EN enables saturating drop/delivery counters.
module gpu_node_router #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned NUM_SPINES = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [5:0]  LOCAL_ADDR = 6'd7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DWIDTH-1:0]            gpu_in_data,
  input  logic                         gpu_in_valid,
  output logic                         gpu_in_ready,
  output logic [DWIDTH-1:0]            gpu_out_data,
  output logic                         gpu_out_valid,
  input  logic                         gpu_out_ready,
  input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [NUM_SPINES-1:0]        spine_in_valid,
  output logic [NUM_SPINES-1:0]        spine_in_ready,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  input  logic [NUM_SPINES-1:0]        spine_out_ready,
  output logic [15:0]                  drop_cnt,
  output logic [15:0]                  local_rx_cnt
);

  localparam int unsigned NIN = NUM_SPINES + 1;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned SW  = $clog2(NUM_SPINES);
  localparam int unsigned RW  = $clog2(NIN);
  localparam int unsigned AW  = 6;

  // Input index 0 is the local NI; input i+1 is spine i.
  logic [DWIDTH-1:0] in_data [NIN];
  logic [DWIDTH-1:0] head    [NIN];
  logic [NIN-1:0]    in_valid, in_ready, full, empty, push, pop, gpu_req, drop_c;

  assign in_data[0]   = gpu_in_data;
  assign in_valid[0]  = gpu_in_valid;
  assign gpu_in_ready = in_ready[0];

  for (genvar i = 0; i < NUM_SPINES; i++) begin : g_spine_in
    assign in_data[i+1]      = spine_in_data[i*DWIDTH +: DWIDTH];
    assign in_valid[i+1]     = spine_in_valid[i];
    assign spine_in_ready[i] = in_ready[i+1];
  end

  // Per-input FIFOs. The extra pointer bit makes full and empty exact at FIFO_DEPTH.
  for (genvar j = 0; j < NIN; j++) begin : g_fifo
    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW:0]       wptr_q, rptr_q;

    assign empty[j]    = (wptr_q == rptr_q);
    assign full[j]     = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign in_ready[j] = !full[j] && !reset;
    assign push[j]     = in_valid[j] && in_ready[j];
    assign head[j]     = mem_q[rptr_q[PW-1:0]];
    assign gpu_req[j]  = !empty[j] && (head[j][DWIDTH-1 -: AW] == LOCAL_ADDR);
    // A spine head that is not addressed to this node is dropped.
    assign drop_c[j]   = (j != 0) && !empty[j] && !gpu_req[j];

    // Pointer update; a push and a pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push[j]) wptr_q <= wptr_q + (PW+1)'(1);
        if (pop[j])  rptr_q <= rptr_q + (PW+1)'(1);
      end
    end

    // Storage write. The array is not reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
      if (push[j]) mem_q[wptr_q[PW-1:0]] <= in_data[j];
    end
  end

  logic [RW-1:0]     rr_q, rr_d, grant_idx;
  logic [RW:0]       cand;
  logic              grant_vld, gpu_can, gpu_load;
  logic [DWIDTH-1:0] gpu_data_q, gpu_data_d;
  logic              gpu_valid_q, gpu_valid_d;
  logic [DWIDTH-1:0] sp_data_q [NUM_SPINES];
  logic [NUM_SPINES-1:0] sp_valid_q, sp_load;
  logic [SW-1:0]     tgt;
  logic              loc_fwd;

  assign tgt     = head[0][DWIDTH-AW +: SW];
  assign loc_fwd = !empty[0] && !gpu_req[0];

  // Round-robin arbitration for gpu_out, local-to-spine forwarding, and pop generation.
  always_comb begin
    pop         = drop_c;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    gpu_load    = 1'b0;
    sp_load     = '0;
    rr_d        = rr_q;
    gpu_data_d  = gpu_data_q;
    gpu_valid_d = gpu_valid_q;
    gpu_can     = !gpu_valid_q || gpu_out_ready;

    for (int unsigned k = 0; k < NIN; k++) begin
      cand = (RW+1)'(rr_q) + (RW+1)'(k);
      if (cand >= (RW+1)'(NIN)) cand = cand - (RW+1)'(NIN);
      if (!grant_vld && gpu_req[cand[RW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[RW-1:0];
      end
    end

    if (grant_vld && gpu_can) begin
      gpu_load       = 1'b1;
      pop[grant_idx] = 1'b1;
      rr_d           = (grant_idx == RW'(NIN-1)) ? '0 : grant_idx + RW'(1);
      gpu_data_d     = head[grant_idx];
      gpu_valid_d    = 1'b1;
    end else if (gpu_out_ready) begin
      gpu_valid_d = 1'b0;
    end

    // The local head waits in place while its target spine register is blocked.
    if (loc_fwd && (!sp_valid_q[tgt] || spine_out_ready[tgt])) begin
      sp_load[tgt] = 1'b1;
      pop[0]       = 1'b1;
    end
  end

  // gpu_out register and the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpu_data_q  <= '0;
      gpu_valid_q <= 1'b0;
      rr_q        <= '0;
    end else begin
      gpu_data_q  <= gpu_data_d;
      gpu_valid_q <= gpu_valid_d;
      rr_q        <= rr_d;
    end
  end

  assign gpu_out_data  = gpu_data_q;
  assign gpu_out_valid = gpu_valid_q;

  for (genvar s = 0; s < NUM_SPINES; s++) begin : g_spine_out
    // Spine output register; holds while valid and not ready.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sp_data_q[s]  <= '0;
        sp_valid_q[s] <= 1'b0;
      end else if (sp_load[s]) begin
        sp_data_q[s]  <= head[0];
        sp_valid_q[s] <= 1'b1;
      end else if (spine_out_ready[s]) begin
        sp_valid_q[s] <= 1'b0;
      end
    end
    assign spine_out_data[s*DWIDTH +: DWIDTH] = sp_data_q[s];
  end

  assign spine_out_valid = sp_valid_q;

`ifdef GPU_NODE_ROUTER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [16:0] drop_sum;

  // Saturating next-state for the drop and delivery counters.
  always_comb begin
    drop_sum   = 17'(drop_cnt_q) + 17'($countones(drop_c));
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    rx_cnt_d   = rx_cnt_q;
    if (gpu_valid_q && gpu_out_ready && (rx_cnt_q != 16'hFFFF)) rx_cnt_d = rx_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      rx_cnt_q   <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  assign drop_cnt     = drop_cnt_q;
  assign local_rx_cnt = rx_cnt_q;
`else
  assign drop_cnt     = '0;
  assign local_rx_cnt = '0;
`endif

endmodule

// File: tb/tb_gpu_node_router.sv
// Directed testbench for gpu_node_router (DWIDTH=16, NUM_SPINES=4, FIFO_DEPTH=4, LOCAL_ADDR=7).
// Expected flits are queued when driven and popped by a negedge monitor on each handshake.
module tb_gpu_node_router;

  localparam int unsigned NS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] gpu_in_data, gpu_out_data;
  logic        gpu_in_valid, gpu_in_ready, gpu_out_valid, gpu_out_ready;
  logic [63:0] spine_in_data, spine_out_data;
  logic [3:0]  spine_in_valid, spine_in_ready, spine_out_valid, spine_out_ready;
  logic [15:0] drop_cnt, local_rx_cnt;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_gpu[$];
  logic [15:0] exp_sp[NS][$];

  gpu_node_router #(
    .DWIDTH(16), .NUM_SPINES(4), .FIFO_DEPTH(4), .LOCAL_ADDR(6'd7)
  ) dut (
    .clk(clk), .reset(reset),
    .gpu_in_data(gpu_in_data), .gpu_in_valid(gpu_in_valid), .gpu_in_ready(gpu_in_ready),
    .gpu_out_data(gpu_out_data), .gpu_out_valid(gpu_out_valid), .gpu_out_ready(gpu_out_ready),
    .spine_in_data(spine_in_data), .spine_in_valid(spine_in_valid), .spine_in_ready(spine_in_ready),
    .spine_out_data(spine_out_data), .spine_out_valid(spine_out_valid), .spine_out_ready(spine_out_ready),
    .drop_cnt(drop_cnt), .local_rx_cnt(local_rx_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stat(input logic [15:0] v);
`ifdef GPU_NODE_ROUTER_STATS_EN
    return v;
`else
    return 16'h0 & v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake must match the head of its expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (gpu_out_valid && gpu_out_ready) begin
        if (exp_gpu.size() == 0) check("gpu_out_extra_flit", 64'(gpu_out_data), 64'hFFFF_FFFF);
        else check("gpu_out_data", 64'(gpu_out_data), 64'(exp_gpu.pop_front()));
      end
      for (int s = 0; s < NS; s++) begin
        if (spine_out_valid[s] && spine_out_ready[s]) begin
          if (exp_sp[s].size() == 0) check("spine_out_extra_flit", 64'(spine_out_data[s*16 +: 16]), 64'hFFFF_FFFF);
          else check("spine_out_data", 64'(spine_out_data[s*16 +: 16]), 64'(exp_sp[s].pop_front()));
        end
      end
    end
  end

  initial begin
    logic [15:0] d;
    int acc;
    gpu_in_data = '0; gpu_in_valid = 1'b0; gpu_out_ready = 1'b1;
    spine_in_data = '0; spine_in_valid = '0; spine_out_ready = '1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gpu_in_ready", 64'(gpu_in_ready), 0);
    check("rst_spine_in_ready", 64'(spine_in_ready), 0);
    check("rst_gpu_out_valid", 64'(gpu_out_valid), 0);
    check("rst_spine_out_valid", 64'(spine_out_valid), 0);
    check("rst_gpu_out_data", 64'(gpu_out_data), 0);
    check("rst_spine_out_data", spine_out_data, 0);
    check("rst_drop_cnt", 64'(drop_cnt), 0);
    check("rst_rx_cnt", 64'(local_rx_cnt), 0);
    tick(); reset = 1'b0;
    tick();

    // Local flit to spine 2, one register of latency after acceptance
    gpu_in_data = 16'h2ABC; gpu_in_valid = 1'b1; exp_sp[2].push_back(16'h2ABC);
    tick(); gpu_in_valid = 1'b0;
    @(negedge clk); check("t1_not_early", 64'(spine_out_valid), 0);
    tick();
    @(negedge clk);
    check("t1_valid", 64'(spine_out_valid), 64'h4);
    check("t1_data", 64'(spine_out_data[47:32]), 64'h2ABC);
    repeat (3) tick();

    // Spine 1 flit addressed to this node
    spine_in_data[31:16] = 16'h1C05; spine_in_valid[1] = 1'b1; exp_gpu.push_back(16'h1C05);
    tick(); spine_in_valid = '0;
    repeat (4) tick();
    check("t2_rx_cnt", 64'(local_rx_cnt), 64'(stat(16'd1)));

    // Spine 1 flit addressed elsewhere is dropped
    spine_in_data[31:16] = 16'h2ABC; spine_in_valid[1] = 1'b1;
    @(negedge clk); check("t3_ready_before", 64'(spine_in_ready[1]), 1);
    tick(); spine_in_valid = '0;
    @(negedge clk); check("t3_ready_after", 64'(spine_in_ready[1]), 1);
    repeat (3) tick();
    check("t3_drop_cnt", 64'(drop_cnt), 64'(stat(16'd1)));
    check("t3_rx_unchanged", 64'(local_rx_cnt), 64'(stat(16'd1)));

    // Reset pulse to return the arbiter pointer to the local input
    reset = 1'b1; tick();
    check("pulse_drop_cnt", 64'(drop_cnt), 0);
    check("pulse_rx_cnt", 64'(local_rx_cnt), 0);
    reset = 1'b0; tick();

    // Five simultaneous requesters drain in round-robin order
    gpu_in_data = 16'h1C01; gpu_in_valid = 1'b1; exp_gpu.push_back(16'h1C01);
    for (int s = 0; s < NS; s++) begin
      spine_in_data[s*16 +: 16] = 16'(16'h1C10 + s);
      exp_gpu.push_back(16'(16'h1C10 + s));
    end
    spine_in_valid = '1;
    tick(); gpu_in_valid = 1'b0; spine_in_valid = '0;
    repeat (8) tick();
    check("t4_rx_cnt", 64'(local_rx_cnt), 64'(stat(16'd5)));
    check("t4_drained", 64'(exp_gpu.size()), 0);

    // Blocked spine 3 holds its register; a concurrent drop still completes
    spine_out_ready[3] = 1'b0;
    gpu_in_data = 16'h0C11; gpu_in_valid = 1'b1;
    spine_in_data[47:32] = 16'h2ABC; spine_in_valid[2] = 1'b1;
    exp_sp[3].push_back(16'h0C11); exp_sp[3].push_back(16'h0C22);
    tick(); gpu_in_data = 16'h0C22; spine_in_valid = '0;
    tick(); gpu_in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("t5_hold_valid", 64'(spine_out_valid), 64'h8);
    check("t5_hold_data", 64'(spine_out_data[63:48]), 64'h0C11);
    check("t5_local_ready", 64'(gpu_in_ready), 1);
    check("t5_drop_cnt", 64'(drop_cnt), 64'(stat(16'd1)));
    tick(); spine_out_ready[3] = 1'b1;
    repeat (4) tick();
    check("t5_drained", 64'(exp_sp[3].size()), 0);

    // gpu_out backpressure: register plus FIFO absorb exactly five flits
    gpu_out_ready = 1'b0; d = 16'h1C20; acc = 0;
    for (int n = 0; n < 10; n++) begin
      spine_in_data[15:0] = d; spine_in_valid[0] = 1'b1;
      @(negedge clk);
      if (spine_in_ready[0]) begin
        acc++;
        exp_gpu.push_back(d);
        d = d + 16'd1;
      end
      tick();
    end
    spine_in_valid = '0;
    @(negedge clk);
    check("t6_accepted", 64'(acc), 5);
    check("t6_ready_low", 64'(spine_in_ready[0]), 0);
    check("t6_hold_data", 64'(gpu_out_data), 64'h1C20);
    check("t6_hold_valid", 64'(gpu_out_valid), 1);
    tick(); gpu_out_ready = 1'b1;
    repeat (8) tick();
    check("t6_rx_cnt", 64'(local_rx_cnt), 64'(stat(16'd10)));
    check("t6_drained", 64'(exp_gpu.size()), 0);

    // Asynchronous reset with flits in flight; nothing stale may emerge afterwards
    gpu_out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      spine_in_data[15:0] = 16'(16'h1C40 + n); spine_in_valid[0] = 1'b1;
      tick();
    end
    spine_in_valid = '0;
    repeat (2) tick();
    @(negedge clk);
    check("t7_valid_before", 64'(gpu_out_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("t7_gpu_valid_async", 64'(gpu_out_valid), 0);
    check("t7_spine_valid_async", 64'(spine_out_valid), 0);
    check("t7_in_ready_async", 64'({gpu_in_ready, spine_in_ready}), 0);
    check("t7_gpu_data_async", 64'(gpu_out_data), 0);
    gpu_out_ready = 1'b1;
    tick(); tick(); reset = 1'b0;
    repeat (10) tick();
    check("t7_drop_cnt", 64'(drop_cnt), 0);
    check("t7_rx_cnt", 64'(local_rx_cnt), 0);
    check("t7_gpu_q_empty", 64'(exp_gpu.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
